// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared fetch-stage definitions
package ifu_fetch_pkg;
  localparam int ILEN = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [ILEN-1:0] instr;
    logic err;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with flush and combinational head
module ifu_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW:0] wptr, rptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop) rptr <= rptr + (PW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wptr[PW-1:0]] <= din;
  assign count = wptr - rptr;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = wptr == rptr;
  assign head = mem[rptr[PW-1:0]];
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: in-order instruction fetch with credit-limited bus requests and jump flush
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int FIFO_DEPTH = 2,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_jump_valid,
  input  logic [AW-1:0] i_jump_pc,
  input  logic i_holding,
  output logic o_ibus_req,
  output logic [AW-1:0] o_ibus_addr,
  input  logic i_ibus_gnt,
  input  logic i_ibus_rvalid,
  input  logic [DW-1:0] i_ibus_rdata,
  input  logic i_ibus_err,
  output logic o_valid,
  output logic [AW-1:0] o_pc,
  output logic [DW-1:0] o_instr,
  output logic o_fetch_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = AW + DW + 1;
  logic [AW-1:0] fetch_pc, resp_pc, jump_pc;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [CW+1:0] inflight;
  logic [EW-1:0] head;
  logic full, empty, grant, drop, keep, push, pop;
  assign jump_pc = i_jump_pc & ~AW'(3);
  assign inflight = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(drop_cnt);
  assign o_ibus_req = rst_n && !i_jump_valid && inflight < (CW+2)'(FIFO_DEPTH);
  assign o_ibus_addr = fetch_pc;
  assign grant = o_ibus_req && i_ibus_gnt;
  assign drop = i_ibus_rvalid && drop_cnt != '0;
  assign keep = i_ibus_rvalid && drop_cnt == '0;
  assign push = keep && !i_jump_valid;
  assign pop = o_valid && !i_holding && !i_jump_valid;
  assign o_valid = !empty;
  assign {o_pc, o_instr, o_fetch_err} = empty ? '0 : head;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else if (i_jump_valid) begin
      fetch_pc <= jump_pc;
      resp_pc <= jump_pc;
      drop_cnt <= drop_cnt + outstanding + CW'(grant) - CW'(i_ibus_rvalid);
      outstanding <= '0;
    end else begin
      if (grant) fetch_pc <= fetch_pc + AW'(PC_STEP);
      if (push) resp_pc <= resp_pc + AW'(PC_STEP);
      outstanding <= outstanding + CW'(grant) - CW'(keep);
      drop_cnt <= drop_cnt - CW'(drop);
    end
  ifu_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(i_jump_valid),
    .din({resp_pc, i_ibus_rdata, i_ibus_err}),
    .full(full),
    .empty(empty),
    .count(count),
    .head(head)
  );
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule
